spi_v3_packet_assembler: RTL

//  Narrow-to-wide packet assembler: collects num_regs small val/rdy packets (nbits_in) into one wide packet (nbits_out).

---
 rtl/spi_v3_pkt_asm_pkg.sv | 14 +
 rtl/spi_v3_packet_assembler_ctrl.sv | 100 ++++++++++
 rtl/spi_v3_packet_assembler.sv | 81 ++++++++
 3 files changed

// File: rtl/spi_v3_pkt_asm_pkg.sv
// Shared types and helpers for the SPI v3 narrow-to-wide packet assembler.
package spi_v3_pkt_asm_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    // Ceiling division: number of nin-bit chunks needed to cover nout bits.
    function automatic int num_chunks(input int nin, input int nout);
        return (nout + nin - 1) / nin;
    endfunction

endpackage

// File: rtl/spi_v3_packet_assembler_ctrl.sv
// FSM, chunk counter and handshake control for the packet assembler.
// Optional flush support is built when SPI_V3_PKT_ASM_FLUSH_EN is defined.
module spi_v3_packet_assembler_ctrl #(
    parameter int num_regs = 4,
    parameter int cnt_bits = 3
) (
    input  logic                clk,
    input  logic                reset,
`ifdef SPI_V3_PKT_ASM_FLUSH_EN
    input  logic                flush,
`endif
    input  logic                req_val,
    output logic                req_rdy,
    output logic                resp_val,
    input  logic                resp_rdy,
    output logic                shift_en,
`ifdef SPI_V3_PKT_ASM_FLUSH_EN
    output logic [cnt_bits-1:0] pad_chunks,
`endif
    output logic                load_first
);
    import spi_v3_pkt_asm_pkg::*;

    localparam logic [cnt_bits-1:0] LAST_CNT = cnt_bits'(num_regs - 1);
`ifdef SPI_V3_PKT_ASM_FLUSH_EN
    localparam logic [cnt_bits-1:0] NREGS    = cnt_bits'(num_regs);
`endif

    state_e              state_q, state_d;
    logic [cnt_bits-1:0] count_q, count_d;
    logic [cnt_bits-1:0] fill_cnt_s;

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state, counter and handshake decode.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        req_rdy    = 1'b0;
        resp_val   = 1'b0;
        shift_en   = 1'b0;
        load_first = 1'b0;
        fill_cnt_s = count_q;
`ifdef SPI_V3_PKT_ASM_FLUSH_EN
        pad_chunks = '0;
`endif
        case (state_q)
            FILL: begin
                req_rdy  = 1'b1;
                shift_en = req_val;
                if (req_val) begin
                    fill_cnt_s = count_q + cnt_bits'(1);
                end else begin
                    fill_cnt_s = count_q;
                end
                if (req_val && (count_q == LAST_CNT)) begin
                    state_d = FULL;
                    count_d = '0;
                end else begin
                    count_d = fill_cnt_s;
`ifdef SPI_V3_PKT_ASM_FLUSH_EN
                    // A partial packet (including this cycle's chunk) is padded and emitted.
                    if (flush && (fill_cnt_s != '0)) begin
                        state_d    = FULL;
                        count_d    = '0;
                        pad_chunks = NREGS - fill_cnt_s;
                    end else begin
                        state_d    = FILL;
                    end
`endif
                end
            end
            FULL: begin
                resp_val = 1'b1;
                req_rdy  = resp_rdy;
                if (resp_rdy) begin
                    state_d    = FILL;
                    load_first = req_val;
                    count_d    = req_val ? cnt_bits'(1) : cnt_bits'(0);
                end else begin
                    state_d    = FULL;
                end
            end
            default: begin
                state_d = FILL;
                count_d = '0;
            end
        endcase
    end

endmodule

// File: rtl/spi_v3_packet_assembler.sv
// Narrow-to-wide packet assembler top: shift-register datapath, first chunk lands in the MSBs.
// Define SPI_V3_PKT_ASM_FLUSH_EN to add the flush port and zero-pad partial packets.
module spi_v3_packet_assembler #(
    parameter int nbits_in  = 8,
    parameter int nbits_out = 32
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef SPI_V3_PKT_ASM_FLUSH_EN
    input  logic                 flush,
`endif
    input  logic                 req_val,
    output logic                 req_rdy,
    input  logic [nbits_in-1:0]  req_msg,
    output logic                 resp_val,
    input  logic                 resp_rdy,
    output logic [nbits_out-1:0] resp_msg
);
    import spi_v3_pkt_asm_pkg::*;

    localparam int num_regs = num_chunks(nbits_in, nbits_out);
    localparam int cnt_bits = $clog2(num_regs) + 1;

    logic                 shift_en_s;
    logic                 load_first_s;
    logic [nbits_out-1:0] data_q, data_d;
    logic [nbits_out-1:0] shift_data_s;
`ifdef SPI_V3_PKT_ASM_FLUSH_EN
    logic [cnt_bits-1:0]  pad_chunks_s;
`endif

    spi_v3_packet_assembler_ctrl #(
        .num_regs (num_regs),
        .cnt_bits (cnt_bits)
    ) u_ctrl (
        .clk        (clk),
        .reset      (reset),
`ifdef SPI_V3_PKT_ASM_FLUSH_EN
        .flush      (flush),
`endif
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .resp_val   (resp_val),
        .resp_rdy   (resp_rdy),
        .shift_en   (shift_en_s),
`ifdef SPI_V3_PKT_ASM_FLUSH_EN
        .pad_chunks (pad_chunks_s),
`endif
        .load_first (load_first_s)
    );

    // Datapath next value: restart, shift-in, hold, then optional zero padding.
    always_comb begin
        shift_data_s = data_q;
        if (load_first_s) begin
            shift_data_s = nbits_out'(req_msg);
        end else if (shift_en_s) begin
            // Truncation here drops the surplus upper bits of the first chunk.
            shift_data_s = {data_q[nbits_out-nbits_in-1:0], req_msg};
        end else begin
            shift_data_s = data_q;
        end
`ifdef SPI_V3_PKT_ASM_FLUSH_EN
        data_d = shift_data_s << (int'(pad_chunks_s) * nbits_in);
`else
        data_d = shift_data_s;
`endif
    end

    // Packet data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign resp_msg = data_q;

endmodule
